// File: rtl/seg7_pkg.sv
// Shared constants and types for the Basys3 seven-segment scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [6:0] SEG_DIGITS [10] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000   // 9
   };

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } slot_t;

   typedef struct packed {
      logic [3:0][3:0] digits;
      logic            dp_en;
      logic            blank_lz;
   } snap_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; 10-15 show a dash.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_DASH;
      if (i_bcd < 4'd10) begin
         o_seg = SEG_DIGITS[i_bcd];
      end
   end

endmodule

// File: rtl/seg7_scanner.sv
// Four-digit common-anode display scanner with per-frame digit snapshot,
// anti-ghosting blank window and leading-zero blanking of the minutes.
module seg7_scanner
   import seg7_pkg::*;
#(
   parameter int REFRESH_CYCLES = 100_000,
   parameter int BLANK_CYCLES   = 2_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] digit0,
   input  logic [3:0] digit1,
   input  logic [3:0] digit2,
   input  logic [3:0] digit3,
   input  logic       dp_en,
   input  logic       blank_lz,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int               DIV_W      = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(REFRESH_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_ACTIVE = DIV_W'(BLANK_CYCLES);

   logic [DIV_W-1:0] r_div, w_div_next;
   slot_t            r_slot, w_slot_next;
   snap_t            r_snap, w_snap_next;
   logic [3:0]       r_an, w_an_next;
   logic [6:0]       r_seg, w_seg_next;
   logic             r_dp, w_dp_next;

   logic [3:0]       w_an_active;
   logic [3:0]       w_digit;
   logic [6:0]       w_seg_dec;
   logic             w_lz_blank;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_an
         assign w_an_active[gi] = (r_slot != 2'(gi));
      end
   endgenerate

   assign w_digit = r_snap.digits[r_slot];

   bcd_to_seg7 u_dec (
      .i_bcd (w_digit),
      .o_seg (w_seg_dec)
   );

   // digit2 only blanks when digit3 is also zero, so both share the digit3 test.
   assign w_lz_blank = r_snap.blank_lz && (r_snap.digits[3] == 4'd0) &&
                       ((r_slot == S3) || ((r_slot == S2) && (r_snap.digits[2] == 4'd0)));

   always_comb begin
      w_div_next  = r_div + 1'b1;
      w_slot_next = r_slot;
      w_snap_next = r_snap;
      w_an_next   = 4'b1111;
      w_seg_next  = SEG_BLANK;
      w_dp_next   = 1'b1;

      if (r_div == DIV_LAST) begin
         w_div_next  = '0;
         w_slot_next = slot_t'(r_slot + 2'd1);
      end

      if ((r_div == '0) && (r_slot == S0)) begin
         w_snap_next.digits   = {digit3, digit2, digit1, digit0};
         w_snap_next.dp_en    = dp_en;
         w_snap_next.blank_lz = blank_lz;
      end

      if (r_div >= DIV_ACTIVE) begin
         w_an_next  = w_an_active;
         w_seg_next = w_lz_blank ? SEG_BLANK : w_seg_dec;
         w_dp_next  = !((r_slot == S2) && r_snap.dp_en);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div  <= '0;
         r_slot <= S0;
         r_snap <= '0;
         r_an   <= 4'b1111;
         r_seg  <= SEG_BLANK;
         r_dp   <= 1'b1;
      end else begin
         r_div  <= w_div_next;
         r_slot <= w_slot_next;
         r_snap <= w_snap_next;
         r_an   <= w_an_next;
         r_seg  <= w_seg_next;
         r_dp   <= w_dp_next;
      end
   end

   assign an  = r_an;
   assign seg = r_seg;
   assign dp  = r_dp;

endmodule

// File: tb/tb_seg7_scanner.sv
// Self-checking bench for seg7_scanner with REFRESH_CYCLES=8, BLANK_CYCLES=2:
// directed scenarios plus randomized inputs against a frame-level reference model.
module tb_seg7_scanner;

   localparam int REFRESH = 8;
   localparam int BLANK   = 2;
   localparam int FRAME   = 4 * REFRESH;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] digit0 = 4'd0, digit1 = 4'd0, digit2 = 4'd0, digit3 = 4'd0;
   logic       dp_en = 1'b0, blank_lz = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   int n_checks = 0;
   int n_fail   = 0;

   seg7_scanner #(
      .REFRESH_CYCLES (REFRESH),
      .BLANK_CYCLES   (BLANK)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .digit0   (digit0),
      .digit1   (digit1),
      .digit2   (digit2),
      .digit3   (digit3),
      .dp_en    (dp_en),
      .blank_lz (blank_lz),
      .seg      (seg),
      .dp       (dp),
      .an       (an)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] v);
      case (v)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   // Reference model: position within the frame drives the expected pins,
   // using the digits captured at the start of the frame.
   int         m_pos;
   int         m_div;
   int         m_slot;
   logic [3:0] m_d [4];
   logic       m_dpen, m_lz, m_blanked;
   logic [3:0] m_an  = 4'hF;
   logic [6:0] m_seg = 7'h7F;
   logic       m_dp  = 1'b1;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pos  = 0;
         for (int i = 0; i < 4; i++) m_d[i] = 4'd0;
         m_dpen = 1'b0;
         m_lz   = 1'b0;
         m_an   = 4'hF;
         m_seg  = 7'h7F;
         m_dp   = 1'b1;
      end else begin
         m_div  = m_pos % REFRESH;
         m_slot = m_pos / REFRESH;
         if (m_div < BLANK) begin
            m_an  = 4'hF;
            m_seg = 7'h7F;
            m_dp  = 1'b1;
         end else begin
            m_an      = ~(4'b0001 << m_slot);
            m_blanked = m_lz && ((m_slot == 3 && m_d[3] == 0) ||
                                 (m_slot == 2 && m_d[3] == 0 && m_d[2] == 0));
            m_seg     = m_blanked ? 7'h7F : ref_seg(m_d[m_slot]);
            m_dp      = !(m_slot == 2 && m_dpen);
         end
         if (m_pos == 0) begin
            m_d[0] = digit0; m_d[1] = digit1; m_d[2] = digit2; m_d[3] = digit3;
            m_dpen = dp_en;
            m_lz   = blank_lz;
         end
         m_pos = (m_pos + 1) % FRAME;
      end
   end

   logic       chk_en = 1'b0;
   logic [3:0] prev_an = 4'hF;

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_an", 32'(an), 32'(m_an));
         check("model_seg", 32'(seg), 32'(m_seg));
         check("model_dp", 32'(dp), 32'(m_dp));
         check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
         if (an != 4'hF && prev_an == 4'hF)
            $display("slot an=%b seg=%b dp=%b t=%0t", an, seg, dp, $time);
         prev_an = an;
      end
   end

   task automatic set_inputs(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                             input logic [3:0] d0, input logic de, input logic lz);
      digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
      dp_en = de; blank_lz = lz;
   endtask

   // Returns at the first negedge of the next frame (its snapshot edge just happened).
   task automatic sync_frame(input string tag);
      logic [3:0] p;
      bit found = 0;
      for (int i = 0; i < 3 * FRAME && !found; i++) begin
         p = an;
         @(negedge clk);
         if (p == 4'b0111 && an == 4'b1111) found = 1;
      end
      if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic show_slot(input int k, input logic [6:0] exp_seg, input logic exp_dp,
                            input string tag);
      logic [3:0] pat;
      bit found = 0;
      pat = ~(4'b0001 << k);
      for (int i = 0; i < 3 * FRAME && !found; i++) begin
         @(negedge clk);
         if (an == pat) found = 1;
      end
      check({tag, "_found"}, 32'(found), 32'd1);
      check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
      check({tag, "_dp"}, 32'(dp), 32'(exp_dp));
   endtask

   task automatic measure_start(input string tag);
      int n = 0;
      int d = 1;
      bit found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         n++;
         if (an != 4'hF) found = 1;
      end
      check({tag, "_first_an"}, 32'(an), 32'b1110);
      check({tag, "_edges"}, 32'(n), 32'(BLANK + 1));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (an != 4'b1110) break;
         d++;
      end
      check({tag, "_len"}, 32'(d), 32'(REFRESH - BLANK));
   endtask

   initial begin
      #1 reset = 1'b1;
      #1 chk_en = 1'b1;
      set_inputs(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp", 32'(dp), 32'd1);
      reset = 1'b0;
      measure_start("boot");

      // Full display
      show_slot(2, 7'b0100100, 1'b0, "full_s2");
      show_slot(3, 7'b1111001, 1'b1, "full_s3");
      show_slot(0, 7'b0011001, 1'b1, "full_s0");
      show_slot(1, 7'b0110000, 1'b1, "full_s1");

      // Leading-zero blanking on and off
      set_inputs(4'd0, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1);
      sync_frame("lz1");
      show_slot(0, 7'b1111000, 1'b1, "lz1_s0");
      show_slot(1, 7'b1000000, 1'b1, "lz1_s1");
      show_slot(2, 7'b1111111, 1'b0, "lz1_s2");
      show_slot(3, 7'b1111111, 1'b1, "lz1_s3");
      set_inputs(4'd0, 4'd0, 4'd0, 4'd7, 1'b1, 1'b0);
      sync_frame("lz0");
      show_slot(0, 7'b1111000, 1'b1, "lz0_s0");
      show_slot(1, 7'b1000000, 1'b1, "lz0_s1");
      show_slot(2, 7'b1000000, 1'b0, "lz0_s2");
      show_slot(3, 7'b1000000, 1'b1, "lz0_s3");

      // Invalid BCD
      set_inputs(4'd1, 4'd2, 4'd3, 4'hC, 1'b0, 1'b0);
      sync_frame("bad");
      show_slot(0, 7'b0111111, 1'b1, "bad_s0");

      // Tear-free update, including a change in the snapshot cycle itself
      set_inputs(4'd5, 4'd6, 4'd7, 4'd3, 1'b0, 1'b0);
      sync_frame("tear");
      show_slot(0, 7'b0110000, 1'b1, "tear_s0_old");
      show_slot(2, 7'b0000010, 1'b1, "tear_s2_old");
      set_inputs(4'd9, 4'd9, 4'd9, 4'd4, 1'b0, 1'b0);
      show_slot(3, 7'b0010010, 1'b1, "tear_s3_old");
      show_slot(0, 7'b0011001, 1'b1, "tear_s0_new");
      show_slot(3, 7'b0010000, 1'b1, "tear_s3_new");
      repeat (REFRESH - BLANK - 1) @(negedge clk);
      check("snapcyc_an", 32'(an), 32'b0111);
      digit0 = 4'd8;
      show_slot(0, 7'b0000000, 1'b1, "snapcyc_s0");

      // Asynchronous reset during slot 1 active window
      show_slot(1, 7'b0010000, 1'b1, "arst_s1");
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_an", 32'(an), 32'hF);
      check("arst_seg", 32'(seg), 32'h7F);
      check("arst_dp", 32'(dp), 32'd1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      measure_start("restart");

      // Randomized inputs; the model checks every cycle
      for (int it = 0; it < 60; it++) begin
         @(negedge clk);
         digit0 = 4'($urandom_range(0, 15));
         digit1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         digit2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         digit3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         dp_en    = 1'($urandom_range(0, 1));
         blank_lz = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 40)) @(negedge clk);
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
